fpu_exec_seq: RTL and testbench
===============================

# fpu_exec_seq

Execute-stage sequencer for the floating-point datapath of the pipelined core. It accepts a decoded FP instruction (4-bit ALU control code plus FPU select flag from the ID/EX register), drives the shared FP arithmetic units with held operands, and counts each unit's fixed latency. It raises a pipeline stall for the duration of the operation and returns the captured result and destination register for the EX/MEM register.

## Interface
- LAT_ADD, 3, cycles for fadd/fsub unit (min 1)
- LAT_MUL, 2, cycles for fmul unit (min 1)
- LAT_DIV, 10, cycles for fdiv unit (min 1)
- LAT_SQRT, 12, cycles for fsqrt unit (min 1)
- CNT_W, 4, counter width; every LAT_* ≤ 2^CNT_W
- clk  in  1  clock
- rstn  in  1  reset: one clock, synchronous, active-low
- start  in  1  EX holds a valid FP instruction (alu_fpu_sig & valid)
- alu_cont  in  4  1000 fadd, 1001 fsub, 1010 fmul, 1011 fdiv, 1100 fsqrt
- src_a, src_b  in  32  operands (src_b ignored for fsqrt)
- rd_in  in  5  destination register
- flush  in  1  kill the in-flight op
- fu_res_add, fu_res_mul, fu_res_div, fu_res_sqrt  in  32 each  unit results
- fu_a, fu_b  out  32  registered operands to units
- fu_op  out  3  000 none, 001 add, 010 sub, 011 mul, 100 div, 101 sqrt
- stall  out  1  freeze IF/ID/EX
- done  out  1  one-cycle result-valid pulse
- result  out  32  captured result
- rd_out  out  5  destination of result
- illegal  out  1  one-cycle pulse, unsupported code with start

## Operation
- States IDLE, BUSY, DONE. Reset → IDLE; cnt, fu_a, fu_b, fu_op, result, rd_out, done, illegal = 0.
- IDLE, start=1, flush=0, legal code: latch src_a/src_b/rd_in into fu_a/fu_b/rd_out, set fu_op, cnt ← LAT(op)−1, → BUSY.
- IDLE, start=1, illegal code (0xxx, 1101–1111): illegal=1 next cycle, stay IDLE, no stall.
- IDLE with flush=1: start ignored.
- BUSY: fu_a/fu_b/fu_op held stable. cnt≠0: decrement. cnt=0: result ← selected fu_res_* (add for fadd/fsub), → DONE.
- DONE: done=1, fu_op=000, → IDLE unconditionally. start in DONE is ignored (same instruction retiring).
- flush in BUSY or DONE: → IDLE next cycle, fu_op=000, done=0, result/rd_out not updated.
- stall = rstn & ((IDLE & start & ~flush & legal) | BUSY). Combinational; never high in DONE.
- fu_op = 000 whenever state ≠ BUSY.

## Timing
- Accept in cycle T. Operands on fu_a/fu_b from T+1. BUSY lasts T+1..T+LAT. Unit result must be valid during T+LAT.
- result/rd_out/done visible in T+LAT+1. stall high T..T+LAT, low in T+LAT+1.
- Total stall cycles = LAT+1. Examples: fadd 4, fmul 3, fdiv 11, fsqrt 13.
- Next FP instruction can be accepted at T+LAT+2 earliest. done is never high in consecutive cycles.
- Reset low in any state: IDLE after the edge. stall=0 while rstn=0. No done for the aborted op.
- flush and cnt=0 in the same cycle: flush wins, no capture.

## Test plan
- fadd 0x3F800000 + 0x40000000, model unit returns 0x40400000 at T+3 → stall T..T+3, done and result=0x40400000 at T+4, rd_out=rd_in.
- fdiv, LAT_DIV=10 → fu_op=100 held T+1..T+10. Exactly 11 stall cycles. fu_res_div sampled only at T+10 (different value at T+9 must not appear).
- fmul followed by fsqrt with start held → second accept at T+4. Two done pulses separated. start in DONE produces no extra op.
- flush at T+5 during fdiv → IDLE at T+6, no done, result keeps prior value, stall low from T+6.
- alu_cont=1110 with start → illegal pulse at T+1, stall never high, fu_op stays 000.
- rstn low at T+2 of fsqrt → all outputs 0 after edge, stall 0 during reset. After release, fadd completes normally with 4 stall cycles.

Source files
------------

// File: rtl/fpu_exec_seq.sv
// FP execute sequencer: holds operands for the selected unit and counts its latency (LAT+1 cycles from accept to done).
// Stall is raised from accept through the last busy cycle; no input backpressure beyond stall.
module fpu_exec_seq #(
  parameter int LAT_ADD  = 3,
  parameter int LAT_MUL  = 2,
  parameter int LAT_DIV  = 10,
  parameter int LAT_SQRT = 12,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [3:0]  alu_cont,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [4:0]  rd_in,
  input  logic        flush,
  input  logic [31:0] fu_res_add,
  input  logic [31:0] fu_res_mul,
  input  logic [31:0] fu_res_div,
  input  logic [31:0] fu_res_sqrt,
  output logic [31:0] fu_a,
  output logic [31:0] fu_b,
  output logic [2:0]  fu_op,
  output logic        stall,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  rd_out,
  output logic        illegal
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic [2:0]       op_q;
  logic [4:0]       rd_q;
  logic [CNT_W-1:0] cnt;
  logic             legal;
  logic [2:0]       dec_op;
  logic             accept;
  logic [31:0]      res_sel;

  function automatic logic [CNT_W-1:0] lat_m1(input logic [2:0] op);
    case (op)
      3'd1, 3'd2: lat_m1 = CNT_W'(LAT_ADD - 1);
      3'd3:       lat_m1 = CNT_W'(LAT_MUL - 1);
      3'd4:       lat_m1 = CNT_W'(LAT_DIV - 1);
      default:    lat_m1 = CNT_W'(LAT_SQRT - 1);
    endcase
  endfunction

  // Codes 1000..1100 map onto unit ops 001..101
  always_comb begin
    legal   = alu_cont[3] & (alu_cont[2:0] <= 3'd4);
    dec_op  = alu_cont[2:0] + 3'd1;
    accept  = (state == IDLE) & start & ~flush & legal;
    case (op_q)
      3'd1, 3'd2: res_sel = fu_res_add;
      3'd3:       res_sel = fu_res_mul;
      3'd4:       res_sel = fu_res_div;
      default:    res_sel = fu_res_sqrt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = BUSY;
      BUSY:    if (flush) state_nxt = IDLE;
               else if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    stall = rstn & (accept | (state == BUSY));
    fu_op = (state == BUSY) ? op_q : 3'd0;
    done  = rstn & ~flush & (state == DONE);
  end

  // rd_out moves together with result so a flushed op leaves both untouched
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt     <= '0;
      fu_a    <= '0;
      fu_b    <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      result  <= '0;
      rd_out  <= '0;
      illegal <= 1'b0;
    end else begin
      illegal <= (state == IDLE) & start & ~flush & ~legal;
      if (accept) begin
        fu_a <= src_a;
        fu_b <= src_b;
        rd_q <= rd_in;
        op_q <= dec_op;
        cnt  <= lat_m1(dec_op);
      end else if (state == BUSY && !flush) begin
        if (cnt == '0) begin
          result <= res_sel;
          rd_out <= rd_q;
        end else begin
          cnt <= cnt - CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fpu_exec_seq.sv
// Randomized bench for fpu_exec_seq against a per-instruction timing model.
module tb_fpu_exec_seq;

  logic        clk = 1'b0;
  logic        rstn, start, flush;
  logic [3:0]  alu_cont;
  logic [31:0] src_a, src_b;
  logic [4:0]  rd_in;
  logic [31:0] fu_res_add, fu_res_mul, fu_res_div, fu_res_sqrt;
  logic [31:0] fu_a, fu_b, result;
  logic [2:0]  fu_op;
  logic        stall, done, illegal;
  logic [4:0]  rd_out;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] b_add, b_mul, b_div, b_sqrt;
  logic [31:0] prev_result = 32'd0;
  logic [4:0]  prev_rd = 5'd0;

  always #5 clk = ~clk;

  fpu_exec_seq dut (
    .clk(clk), .rstn(rstn), .start(start), .alu_cont(alu_cont),
    .src_a(src_a), .src_b(src_b), .rd_in(rd_in), .flush(flush),
    .fu_res_add(fu_res_add), .fu_res_mul(fu_res_mul),
    .fu_res_div(fu_res_div), .fu_res_sqrt(fu_res_sqrt),
    .fu_a(fu_a), .fu_b(fu_b), .fu_op(fu_op), .stall(stall), .done(done),
    .result(result), .rd_out(rd_out), .illegal(illegal)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lat_of(input logic [3:0] code);
    case (code)
      4'b1000, 4'b1001: return 3;
      4'b1010:          return 2;
      4'b1011:          return 10;
      default:          return 12;
    endcase
  endfunction

  function automatic logic [2:0] unit_op(input logic [3:0] code);
    case (code)
      4'b1000: return 3'b001;
      4'b1001: return 3'b010;
      4'b1010: return 3'b011;
      4'b1011: return 3'b100;
      default: return 3'b101;
    endcase
  endfunction

  function automatic logic [31:0] unit_base(input logic [3:0] code);
    case (code)
      4'b1000, 4'b1001: return b_add;
      4'b1010:          return b_mul;
      4'b1011:          return b_div;
      default:          return b_sqrt;
    endcase
  endfunction

  task automatic new_bases();
    b_add = $urandom; b_mul = $urandom; b_div = $urandom; b_sqrt = $urandom;
  endtask

  // Unit outputs change every cycle, so only the value at cycle k==LAT is the right one
  task automatic drive_fu(input int k);
    fu_res_add  = b_add  ^ 32'(k);
    fu_res_mul  = b_mul  ^ 32'(k);
    fu_res_div  = b_div  ^ 32'(k);
    fu_res_sqrt = b_sqrt ^ 32'(k);
  endtask

  // Entered just after a negedge; flush_at = busy cycle index (1..LAT) to flush, 0 for none
  task automatic run_op(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int flush_at, input bit hold);
    int L;
    int stalls;
    logic [31:0] exp_res;
    L = lat_of(code);
    stalls = 0;
    exp_res = unit_base(code) ^ 32'(L);
    start = 1'b1; alu_cont = code; src_a = a; src_b = b; rd_in = rd; flush = 1'b0;
    drive_fu(0);
    #1;
    chk("accept_stall", stall, 1);
    chk("idle_fu_op", fu_op, 0);
    chk("idle_done", done, 0);
    stalls += int'(stall);
    @(negedge clk);
    if (!hold) begin
      start = 1'b0; src_a = $urandom; src_b = $urandom; rd_in = 5'($urandom);
    end
    for (int k = 1; k <= L; k++) begin
      drive_fu(k);
      flush = (k == flush_at);
      #1;
      chk("busy_stall", stall, 1);
      chk("busy_fu_op", fu_op, unit_op(code));
      chk("busy_fu_a", fu_a, a);
      chk("busy_fu_b", fu_b, b);
      chk("busy_done", done, 0);
      stalls += int'(stall);
      @(negedge clk);
      if (k == flush_at) begin
        flush = 1'b0;
        #1;
        chk("flush_stall", stall, 0);
        chk("flush_done", done, 0);
        chk("flush_fu_op", fu_op, 0);
        chk("flush_result", result, prev_result);
        chk("flush_rd", rd_out, prev_rd);
        return;
      end
    end
    drive_fu(L + 1);
    #1;
    chk("done_pulse", done, 1);
    chk("done_result", result, exp_res);
    chk("done_rd", rd_out, rd);
    chk("done_stall", stall, 0);
    chk("done_fu_op", fu_op, 0);
    stalls += int'(stall);
    chk("stall_cycles", stalls, L + 1);
    prev_result = exp_res;
    prev_rd = rd;
    @(negedge clk);
    if (!hold) begin
      start = 1'b0;
      #1;
      chk("done_one_cycle", done, 0);
      chk("no_reaccept", fu_op, 0);
    end
  endtask

  task automatic run_illegal(input logic [3:0] code);
    start = 1'b1; alu_cont = code; flush = 1'b0;
    #1;
    chk("illegal_stall", stall, 0);
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("illegal_pulse", illegal, 1);
    chk("illegal_stall2", stall, 0);
    chk("illegal_fu_op", fu_op, 0);
    @(negedge clk);
    #1;
    chk("illegal_clear", illegal, 0);
  endtask

  logic [3:0] legal_codes [5] = '{4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b1100};
  logic [3:0] bad_codes [4] = '{4'b0011, 4'b1101, 4'b1110, 4'b1111};

  initial begin
    rstn = 1'b0; start = 1'b0; flush = 1'b0; alu_cont = 4'd0;
    src_a = 32'd0; src_b = 32'd0; rd_in = 5'd0;
    new_bases(); drive_fu(0);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_fu_a", fu_a, 0);
    chk("rst_fu_op", fu_op, 0);
    chk("rst_result", result, 0);
    chk("rst_rd", rd_out, 0);
    chk("rst_done", done, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_stall", stall, 0);
    @(negedge clk);
    rstn = 1'b1;

    // fadd 1.0 + 2.0 with the unit returning 3.0 exactly at T+3
    new_bases(); b_add = 32'h40400003;
    run_op(4'b1000, 32'h3F800000, 32'h40000000, 5'd7, 0, 1'b0);
    chk("fadd_result", result, 32'h40400000);

    new_bases();
    run_op(4'b1011, $urandom, $urandom, 5'd12, 0, 1'b0);

    // fmul then fsqrt with start held through the fmul's DONE cycle
    new_bases();
    run_op(4'b1010, $urandom, $urandom, 5'd3, 0, 1'b1);
    new_bases();
    run_op(4'b1100, $urandom, $urandom, 5'd4, 0, 1'b0);

    new_bases();
    run_op(4'b1011, $urandom, $urandom, 5'd9, 5, 1'b0);

    run_illegal(4'b1110);

    // start with flush in IDLE is ignored
    start = 1'b1; alu_cont = 4'b1000; flush = 1'b1;
    #1;
    chk("idle_flush_stall", stall, 0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1;
    chk("idle_flush_op", fu_op, 0);
    @(negedge clk);

    // reset in the middle of an fsqrt
    new_bases();
    start = 1'b1; alu_cont = 4'b1100; src_a = $urandom; drive_fu(0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("rst_mid_stall", stall, 0);
    @(negedge clk);
    #1;
    chk("rst_mid_fu_op", fu_op, 0);
    chk("rst_mid_fu_a", fu_a, 0);
    chk("rst_mid_result", result, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_stall2", stall, 0);
    rstn = 1'b1;
    prev_result = 32'd0; prev_rd = 5'd0;
    @(negedge clk);
    new_bases();
    run_op(4'b1000, $urandom, $urandom, 5'd21, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        run_illegal(bad_codes[$urandom_range(0, 3)]);
      end else begin
        logic [3:0] c;
        int fa;
        bit h;
        c = legal_codes[$urandom_range(0, 4)];
        fa = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, lat_of(c))) : 0;
        h = (fa == 0) && ($urandom_range(0, 3) == 0);
        new_bases();
        run_op(c, $urandom, $urandom, 5'($urandom), fa, h);
      end
    end
    start = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
